// File: rtl/key_text_if.sv
// Key-event input and video-RAM/cursor status bundle for key_text_writer.
// The slave side is the writer; the master side is whoever produces keys and watches the screen.
interface key_text_if;
  logic        key_strobe;
  logic [7:0]  key_ascii;
  logic        vram_we;
  logic [11:0] vram_addr;
  logic [7:0]  vram_data;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic [4:0]  top_row;
  logic        busy;
  logic        line_end;
  logic        overflow;

  modport master (
    output key_strobe, key_ascii,
    input  vram_we, vram_addr, vram_data, cursor_x, cursor_y, top_row, busy, line_end, overflow
  );

  modport slave (
    input  key_strobe, key_ascii,
    output vram_we, vram_addr, vram_data, cursor_x, cursor_y, top_row, busy, line_end, overflow
  );
endinterface

// File: rtl/key_text_writer.sv
// Turns one-cycle ASCII key events into character-mode VRAM writes, tracking the cursor and
// scrolling by rotating top_row; newly exposed rows and the whole screen after reset are blanked.
module key_text_writer #(
  parameter int unsigned COLS  = 70,
  parameter int unsigned ROWS  = 30,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input logic       clk,
  input logic       rst,
  key_text_if.slave bus_io
);
  localparam logic [6:0]  XMax     = 7'(COLS - 1);
  localparam logic [4:0]  YMax     = 5'(ROWS - 1);
  localparam logic [11:0] LastCell = 12'(COLS * ROWS - 1);
  localparam logic [11:0] LastCol  = 12'(COLS - 1);
  localparam logic [5:0]  RowsW    = 6'(ROWS);
  localparam logic [11:0] ColsW    = 12'(COLS);

  typedef enum logic [1:0] {StInit, StIdle, StClear} state_e;

  state_e      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [6:0]  cursor_x_q, cursor_x_d;
  logic [4:0]  cursor_y_q, cursor_y_d;
  logic [4:0]  top_row_q, top_row_d;
  logic        vram_we_q, vram_we_d;
  logic [11:0] vram_addr_q, vram_addr_d;
  logic [7:0]  vram_data_q, vram_data_d;
  logic        busy_q, busy_d;
  logic        line_end_q, line_end_d;
  logic        overflow_q, overflow_d;
  logic        pend_valid_q, pend_valid_d;
  logic [7:0]  pend_key_q, pend_key_d;

  logic [5:0]  row_sum;
  logic [4:0]  phys_row;
  logic [11:0] row_base;
  logic        take_direct, pend_pop, key_valid, advance;
  logic [7:0]  key_code;

  // Physical row of the cursor; both operands are < ROWS so one subtract suffices.
  always_comb begin
    row_sum  = {1'b0, top_row_q} + {1'b0, cursor_y_q};
    phys_row = (row_sum >= RowsW) ? 5'(row_sum - RowsW) : row_sum[4:0];
    row_base = 12'(phys_row) * ColsW;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cursor_x_d   = cursor_x_q;
    cursor_y_d   = cursor_y_q;
    top_row_d    = top_row_q;
    vram_we_d    = 1'b0;
    vram_addr_d  = vram_addr_q;
    vram_data_d  = vram_data_q;
    line_end_d   = 1'b0;
    overflow_d   = overflow_q;
    pend_valid_d = pend_valid_q;
    pend_key_d   = pend_key_q;
    key_valid    = 1'b0;
    key_code     = pend_key_q;
    advance      = 1'b0;

    take_direct = (state_q == StIdle) && !pend_valid_q && bus_io.key_strobe;
    pend_pop    = (state_q == StIdle) && pend_valid_q;
    if (pend_pop) pend_valid_d = 1'b0;
    if (bus_io.key_strobe && !take_direct) begin
      if (!pend_valid_q || pend_pop) begin
        pend_valid_d = 1'b1;
        pend_key_d   = bus_io.key_ascii;
      end else begin
        overflow_d = 1'b1;
      end
    end

    unique case (state_q)
      StInit: begin
        vram_we_d   = 1'b1;
        vram_addr_d = cnt_q;
        vram_data_d = BLANK;
        cnt_d       = cnt_q + 12'd1;
        if (cnt_q == LastCell) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      StClear: begin
        vram_we_d   = 1'b1;
        vram_addr_d = row_base + cnt_q;
        vram_data_d = BLANK;
        cnt_d       = cnt_q + 12'd1;
        if (cnt_q == LastCol) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      StIdle: begin
        if (pend_valid_q) begin
          key_valid = 1'b1;
          key_code  = pend_key_q;
        end else if (bus_io.key_strobe) begin
          key_valid = 1'b1;
          key_code  = bus_io.key_ascii;
        end
        if (key_valid) begin
          if (key_code >= 8'h20 && key_code <= 8'h7e) begin
            vram_we_d   = 1'b1;
            vram_addr_d = row_base + 12'(cursor_x_q);
            vram_data_d = key_code;
            if (cursor_x_q < XMax) begin
              cursor_x_d = cursor_x_q + 7'd1;
            end else begin
              cursor_x_d = '0;
              advance    = 1'b1;
            end
          end else if (key_code == 8'h08) begin
            if (cursor_x_q != '0) begin
              cursor_x_d  = cursor_x_q - 7'd1;
              vram_we_d   = 1'b1;
              vram_addr_d = row_base + 12'(cursor_x_q - 7'd1);
              vram_data_d = BLANK;
            end
          end else if (key_code == 8'h0a) begin
            line_end_d = 1'b1;
            cursor_x_d = '0;
            advance    = 1'b1;
          end
        end
        if (advance) begin
          if (cursor_y_q < YMax) cursor_y_d = cursor_y_q + 5'd1;
          else top_row_d = (top_row_q == YMax) ? 5'd0 : top_row_q + 5'd1;
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StInit;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StInit;
      cnt_q        <= '0;
      cursor_x_q   <= '0;
      cursor_y_q   <= '0;
      top_row_q    <= '0;
      vram_we_q    <= 1'b0;
      vram_addr_q  <= '0;
      vram_data_q  <= '0;
      busy_q       <= 1'b0;
      line_end_q   <= 1'b0;
      overflow_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_key_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cursor_x_q   <= cursor_x_d;
      cursor_y_q   <= cursor_y_d;
      top_row_q    <= top_row_d;
      vram_we_q    <= vram_we_d;
      vram_addr_q  <= vram_addr_d;
      vram_data_q  <= vram_data_d;
      busy_q       <= busy_d;
      line_end_q   <= line_end_d;
      overflow_q   <= overflow_d;
      pend_valid_q <= pend_valid_d;
      pend_key_q   <= pend_key_d;
    end
  end

  assign bus_io.vram_we   = vram_we_q;
  assign bus_io.vram_addr = vram_addr_q;
  assign bus_io.vram_data = vram_data_q;
  assign bus_io.cursor_x  = cursor_x_q;
  assign bus_io.cursor_y  = cursor_y_q;
  assign bus_io.top_row   = top_row_q;
  assign bus_io.busy      = busy_q;
  assign bus_io.line_end  = line_end_q;
  assign bus_io.overflow  = overflow_q;
endmodule
